// File: rtl/wb_dma_qchan_pkg.sv
// ============================================================================
// wb_dma_qchan_pkg : shared state encoding and defaults for the Q-channel ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_dma_qchan_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_SAVE    = 3'd2,
    ST_STOP    = 3'd3,
    ST_RESTORE = 3'd4,
    ST_DENY    = 3'd5
  } qchan_state_e;

  localparam int DEF_NUM_CH      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DRAIN_MAX   = 256;
  localparam int DEF_RESTORE_CYC = 2;

endpackage

`default_nettype wire

// File: rtl/wb_dma_qchan_sync.sv
// ============================================================================
// wb_dma_qchan_sync : qreqn synchroniser chain, resets high; 0 stages = wire
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_dma_qchan_sync
  import wb_dma_qchan_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_chain
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= d_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign q_o = sync_q[SYNC_STAGES-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/wb_dma_qchan_ctrl.sv
// ============================================================================
// wb_dma_qchan_ctrl : Q-channel quiescence/retention controller for WB DMA.
// Optional wake/timeout deny path enabled by macro QCHAN_DENY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_dma_qchan_ctrl
  import wb_dma_qchan_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DRAIN_MAX   = DEF_DRAIN_MAX,
  parameter int RESTORE_CYC = DEF_RESTORE_CYC
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              qreqn,
  input  logic [NUM_CH-1:0] ch_busy,
  input  logic              wake_i,
  output logic              qacceptn,
  output logic              qdeny,
  output logic [NUM_CH-1:0] ch_pause,
  output logic              pr_save,
  output logic              pr_restore
);

  localparam int RCNT_W = (RESTORE_CYC < 2) ? 1 : $clog2(RESTORE_CYC + 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESTORE_CYC - 1);

  logic              qreqn_s;
  qchan_state_e      state_q;
  logic              acc_n_q;
  logic              deny_q;
  logic [NUM_CH-1:0] pause_q;
  logic              save_q;
  logic              restore_q;
  logic [RCNT_W-1:0] rcnt_q;

  wb_dma_qchan_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (qreqn),
    .q_o  (qreqn_s)
  );

`ifdef QCHAN_DENY_EN
  localparam int CNT_W = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DRAIN_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
`else
  logic unused_wake;
  assign unused_wake = wake_i;
`endif

  // qreqn_s release in DRAIN is checked first so qdeny/qacceptn can only
  // change state while the request is still held low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      acc_n_q   <= 1'b1;
      deny_q    <= 1'b0;
      pause_q   <= '0;
      save_q    <= 1'b0;
      restore_q <= 1'b0;
      rcnt_q    <= '0;
`ifdef QCHAN_DENY_EN
      cnt_q     <= '0;
`endif
    end else begin
      save_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (!qreqn_s) begin
            state_q <= ST_DRAIN;
            pause_q <= '1;
`ifdef QCHAN_DENY_EN
            cnt_q   <= '0;
`endif
          end
        end
        ST_DRAIN: begin
`ifdef QCHAN_DENY_EN
          cnt_q <= cnt_d;
`endif
          if (qreqn_s) begin
            state_q <= ST_RUN;
            pause_q <= '0;
`ifdef QCHAN_DENY_EN
          end else if (wake_i) begin
            state_q <= ST_DENY;
            deny_q  <= 1'b1;
            pause_q <= '0;
`endif
          end else if (!(|ch_busy)) begin
            state_q <= ST_SAVE;
            save_q  <= 1'b1;
`ifdef QCHAN_DENY_EN
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_DENY;
            deny_q  <= 1'b1;
            pause_q <= '0;
`endif
          end
        end
        ST_SAVE: begin
          if (qreqn_s) begin
            state_q   <= ST_RESTORE;
            restore_q <= 1'b1;
            rcnt_q    <= '0;
          end else begin
            state_q <= ST_STOP;
            acc_n_q <= 1'b0;
          end
        end
        ST_STOP: begin
          if (qreqn_s) begin
            state_q   <= ST_RESTORE;
            restore_q <= 1'b1;
            rcnt_q    <= '0;
          end
        end
        ST_RESTORE: begin
          if (rcnt_q == RCNT_LAST) begin
            state_q   <= ST_RUN;
            restore_q <= 1'b0;
            acc_n_q   <= 1'b1;
            pause_q   <= '0;
          end else begin
            rcnt_q <= rcnt_q + RCNT_W'(1);
          end
        end
`ifdef QCHAN_DENY_EN
        ST_DENY: begin
          if (qreqn_s) begin
            state_q <= ST_RUN;
            deny_q  <= 1'b0;
          end
        end
`endif
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign qacceptn   = acc_n_q;
  assign qdeny      = deny_q;
  assign ch_pause   = pause_q;
  assign pr_save    = save_q;
  assign pr_restore = restore_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_dma_qchan_ctrl.sv
// ============================================================================
// tb_wb_dma_qchan_ctrl : table-driven Q-channel transactions with scoreboard
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wb_dma_qchan_ctrl;
  import wb_dma_qchan_pkg::*;

  localparam int NUM_CH = 8;
  localparam int SYNC   = 2;
  localparam int DMAX   = 16;
  localparam int RCYC   = 2;
`ifdef QCHAN_DENY_EN
  localparam bit DEN = 1'b1;
`else
  localparam bit DEN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              qreqn;
  logic [NUM_CH-1:0] busy;
  logic              wake;
  logic              qacceptn;
  logic              qdeny;
  logic [NUM_CH-1:0] pause;
  logic              pr_save;
  logic              pr_restore;

  always #5 clk = ~clk;

  wb_dma_qchan_ctrl #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC), .DRAIN_MAX(DMAX), .RESTORE_CYC(RCYC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .qreqn(qreqn), .ch_busy(busy), .wake_i(wake),
    .qacceptn(qacceptn), .qdeny(qdeny), .ch_pause(pause),
    .pr_save(pr_save), .pr_restore(pr_restore)
  );

  typedef struct {
    logic [7:0] busy;
    int         clear_k;   // busy drops after this many edges past DRAIN entry
    int         wake_k;    // wake rises after this many edges past DRAIN entry
    logic       exp_deny;
    int         exp_lat;   // edges from qreqn drive to accept/deny
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    vec_t e;
    int   cyc;
    int   saves;
    int   rest_cnt;
    int   rise_lat;
    bit   done;
    bit   pause_ok;
    bit   acc_fell;
    bit   overlap;

    vecs[0] = '{8'h00, 0,   -1, 1'b0, 5};
    vecs[1] = '{8'h04, 10,  -1, 1'b0, 15};
    vecs[2] = '{8'h01, 300, -1, DEN, DEN ? 19 : 305};
    vecs[3] = '{8'h02, 6,   6,  DEN, DEN ? 10 : 11};
    vecs[4] = '{8'h80, 20,  3,  DEN, DEN ? 7 : 25};
    vecs[5] = '{8'hFF, 1,   -1, 1'b0, 6};

    rst = 1'b1; qreqn = 1'b1; busy = '0; wake = 1'b0;
    tick(); tick();
    chk("rst_qacceptn", qacceptn, 1);
    chk("rst_qdeny", qdeny, 0);
    chk("rst_pause", pause, 0);
    chk("rst_prs", {pr_save, pr_restore}, 0);
    @(negedge clk) rst = 1'b0;
    tick(); tick();
    chk("idle_qacceptn", qacceptn, 1);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      busy = v.busy; wake = 1'b0; qreqn = 1'b0;
      sb.push_back(v);
      cyc = 0; saves = 0; done = 1'b0; pause_ok = 1'b1;
      while (!done && cyc < 2000) begin
        tick(); cyc++;
        if (pr_save) saves++;
        if (cyc >= SYNC + 1 && qacceptn && !qdeny && pause !== 8'hFF) pause_ok = 1'b0;
        if (!qacceptn || qdeny) done = 1'b1;
        else begin
          if (cyc == 3 + v.clear_k) busy = '0;
          if (cyc == 3 + v.wake_k) wake = 1'b1;
        end
      end
      chk("response_bound", done, 1);
      e = sb.pop_front();
      chk("outcome_deny", qdeny, e.exp_deny);
      chk("qacceptn_resp", qacceptn, e.exp_deny);
      chk("resp_latency", cyc, e.exp_lat);
      chk("save_pulses", saves, e.exp_deny ? 0 : 1);
      chk("pause_resp", pause, e.exp_deny ? 8'h00 : 8'hFF);
      chk("pause_drain", pause_ok, 1);
      wake = 1'b0;

      qreqn = 1'b1;
      cyc = 0; rest_cnt = 0; rise_lat = 0; acc_fell = 1'b0; overlap = 1'b0;
      for (int c = 0; c < 8; c++) begin
        tick(); cyc++;
        if (pr_restore) rest_cnt++;
        if (pr_restore && (qdeny || pr_save)) overlap = 1'b1;
        if (e.exp_deny) begin
          if (!qacceptn) acc_fell = 1'b1;
          if (!qdeny && rise_lat == 0) rise_lat = cyc;
        end else if (qacceptn && rise_lat == 0) begin
          rise_lat = cyc;
        end
      end
      chk("exit_latency", rise_lat, e.exp_deny ? 3 : SYNC + 1 + RCYC);
      chk("restore_cycles", rest_cnt, e.exp_deny ? 0 : RCYC);
      chk("exit_acc_glitch", acc_fell, 0);
      chk("restore_overlap", overlap, 0);
      chk("exit_pause", pause, 0);
      busy = '0;
      tick();
    end

    // reset asserted while the restore window is open
    qreqn = 1'b0;
    repeat (5) tick();
    chk("mr_accept", qacceptn, 0);
    qreqn = 1'b1;
    repeat (3) tick();
    chk("mr_restore_on", pr_restore, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_qacceptn", qacceptn, 1);
    chk("mr_restore_off", pr_restore, 0);
    chk("mr_pause", pause, 0);
    chk("mr_state", dut.state_q, ST_RUN);
    @(negedge clk) rst = 1'b0;
    tick(); tick();
    chk("mr_after", {qacceptn, qdeny, pr_restore}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
